rs_issue_scheduler: RTL and testbench



---
 rtl/rs_sched_pkg.sv | 34 +++
 rtl/rs_oldest2_select.sv | 64 ++++++
 rtl/rs_issue_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_sched_pkg.sv
// Shared types and constants for the reservation-station issue scheduler.
//
// Contents:
//   - Default sizes for the scheduler parameters.
//   - AGE_SENTINEL: the all-ones age. It is never stamped on a live entry.
//   - idx_width(): index width helper for an N-entry structure.
//   - rs_entry_t: one reservation-station entry. The age field is stored at the
//     full AGE_W_MAX width. Narrower age counters are zero-extended into it, so
//     the selector always compares ages at one fixed width.
package rs_sched_pkg;

  localparam int RS_SIZE_DEF      = 4;
  localparam int TAG_W            = 6;
  localparam int PAYLOAD_W        = 32;
  localparam int AGE_W_MAX        = 16;
  localparam int WAKEUP_PORTS_DEF = 2;

  localparam logic [AGE_W_MAX-1:0] AGE_SENTINEL = '1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 src1_rdy;
    logic                 src2_rdy;
    logic [TAG_W-1:0]     src1_tag;
    logic [TAG_W-1:0]     src2_tag;
    logic [AGE_W_MAX-1:0] age;
    logic [PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest2_select.sv
// Combinational pick of the oldest and second-oldest ready entries.
//
// Ports:
//   ready_i        per-entry ready bit
//   ages_i         per-entry age; entry i occupies bits [i*AGE_W_MAX +: AGE_W_MAX]
//   first_valid_o  some entry is ready
//   first_idx_o    index of the oldest ready entry
//   second_valid_o a second ready entry exists
//   second_idx_o   index of the second-oldest ready entry
//
// The comparison is a strict less-than, and entries are scanned from index 0
// upward. An equal age therefore never displaces an earlier pick, and the
// lower index wins a tie.
module rs_oldest2_select
  import rs_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]           ready_i,
  input  logic [N*AGE_W_MAX-1:0] ages_i,
  output logic                   first_valid_o,
  output logic [IDX_W-1:0]       first_idx_o,
  output logic                   second_valid_o,
  output logic [IDX_W-1:0]       second_idx_o
);

  logic [AGE_W_MAX-1:0] first_age;
  logic [AGE_W_MAX-1:0] first_cand;
  logic [AGE_W_MAX-1:0] second_age;
  logic [AGE_W_MAX-1:0] second_cand;

  always_comb begin
    first_valid_o = 1'b0;
    first_idx_o   = '0;
    first_age     = AGE_SENTINEL;
    first_cand    = '0;
    for (int i = 0; i < N; i++) begin
      first_cand = ages_i[i*AGE_W_MAX +: AGE_W_MAX];
      if (ready_i[i] && (!first_valid_o || (first_cand < first_age))) begin
        first_valid_o = 1'b1;
        first_idx_o   = IDX_W'(i);
        first_age     = first_cand;
      end
    end
  end

  always_comb begin
    second_valid_o = 1'b0;
    second_idx_o   = '0;
    second_age     = AGE_SENTINEL;
    second_cand    = '0;
    for (int i = 0; i < N; i++) begin
      second_cand = ages_i[i*AGE_W_MAX +: AGE_W_MAX];
      if (ready_i[i] && first_valid_o && (first_idx_o != IDX_W'(i)) &&
          (!second_valid_o || (second_cand < second_age))) begin
        second_valid_o = 1'b1;
        second_idx_o   = IDX_W'(i);
        second_age     = second_cand;
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler for one execution cluster.
//
// The scheduler holds up to RS_SIZE micro-ops. It allocates one per cycle into
// the lowest free slot and tracks source readiness through a wakeup CAM. Each
// cycle it offers the oldest ready entry on port 0 and the second-oldest ready
// entry on port 1.
//
// Ports:
//   clk_i, rst_i         clock and synchronous active-high reset
//   flush_i              discard all entries at the next edge
//   alloc_*              dispatch interface (valid/ready, source tags and
//                        ready bits, payload)
//   wakeup_valid_i/tag_i per-bus broadcast of a produced physical tag
//   issueK_*             two issue ports (valid/ready, payload)
//   occupancy_o          registered count of valid entries
//
// Handshake, applying to the alloc and both issue ports: a transfer happens
// in a cycle where valid and ready are both high at the rising edge. The
// issue valids are recomputed every cycle and may drop without a transfer.
// alloc_ready_o does not depend on alloc_valid_i.
//
// TAG_WIDTH and PAYLOAD_WIDTH must match the widths of the package entry
// struct. AGE_WIDTH may be narrower than AGE_W_MAX.
module rs_issue_scheduler
  import rs_sched_pkg::*;
#(
  parameter int RS_SIZE        = RS_SIZE_DEF,
  parameter int RS_INDEX_WIDTH = idx_width(RS_SIZE),
  parameter int AGE_WIDTH      = AGE_W_MAX,
  parameter int TAG_WIDTH      = TAG_W,
  parameter int PAYLOAD_WIDTH  = PAYLOAD_W,
  parameter int WAKEUP_PORTS   = WAKEUP_PORTS_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           alloc_valid_i,
  output logic                           alloc_ready_o,
  input  logic [TAG_WIDTH-1:0]           alloc_src1_tag_i,
  input  logic [TAG_WIDTH-1:0]           alloc_src2_tag_i,
  input  logic                           alloc_src1_rdy_i,
  input  logic                           alloc_src2_rdy_i,
  input  logic [PAYLOAD_WIDTH-1:0]       alloc_payload_i,
  input  logic [WAKEUP_PORTS-1:0]        wakeup_valid_i,
  input  logic [WAKEUP_PORTS*TAG_WIDTH-1:0] wakeup_tag_i,
  output logic                           issue0_valid_o,
  input  logic                           issue0_ready_i,
  output logic [PAYLOAD_WIDTH-1:0]       issue0_payload_o,
  output logic                           issue1_valid_o,
  input  logic                           issue1_ready_i,
  output logic [PAYLOAD_WIDTH-1:0]       issue1_payload_o,
  output logic [RS_INDEX_WIDTH:0]        occupancy_o
);

  localparam int OCC_W = RS_INDEX_WIDTH + 1;
  // Allocation stops when the counter reaches this value, so a live entry
  // never carries it.
  localparam logic [AGE_WIDTH-1:0] AGE_LAST = AGE_SENTINEL[AGE_WIDTH-1:0];

  rs_entry_t                   ent_q [RS_SIZE];
  logic [AGE_WIDTH-1:0]        age_cnt_q;
  logic [OCC_W-1:0]            occ_q;

  logic                        any_free;
  logic [RS_INDEX_WIDTH-1:0]   free_idx;
  logic [RS_SIZE-1:0]          wake1;
  logic [RS_SIZE-1:0]          wake2;
  logic                        alloc_wake1;
  logic                        alloc_wake2;
  logic [RS_SIZE-1:0]          ready_vec;
  logic [RS_SIZE*AGE_W_MAX-1:0] age_vec;
  logic                        sel0_valid;
  logic                        sel1_valid;
  logic [RS_INDEX_WIDTH-1:0]   sel0_idx;
  logic [RS_INDEX_WIDTH-1:0]   sel1_idx;
  logic                        alloc_fire;
  logic                        issue0_fire;
  logic                        issue1_fire;

  // Lowest-index free slot. The scan runs downward so the last hit is the
  // lowest index. The scan reads registered state only, so a slot freed by
  // issue this cycle is not reused until next cycle.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        any_free = 1'b1;
        free_idx = RS_INDEX_WIDTH'(i);
      end
    end
  end

  // Wakeup CAM. It covers the stored entries and the entry being allocated
  // this cycle, so a broadcast that coincides with allocation is not lost.
  always_comb begin
    wake1       = '0;
    wake2       = '0;
    alloc_wake1 = 1'b0;
    alloc_wake2 = 1'b0;
    for (int p = 0; p < WAKEUP_PORTS; p++) begin
      if (wakeup_valid_i[p]) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent_q[i].src1_tag == wakeup_tag_i[p*TAG_WIDTH +: TAG_WIDTH]) wake1[i] = 1'b1;
          if (ent_q[i].src2_tag == wakeup_tag_i[p*TAG_WIDTH +: TAG_WIDTH]) wake2[i] = 1'b1;
        end
        if (alloc_src1_tag_i == wakeup_tag_i[p*TAG_WIDTH +: TAG_WIDTH]) alloc_wake1 = 1'b1;
        if (alloc_src2_tag_i == wakeup_tag_i[p*TAG_WIDTH +: TAG_WIDTH]) alloc_wake2 = 1'b1;
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    age_vec   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
      age_vec[i*AGE_W_MAX +: AGE_W_MAX] = ent_q[i].age;
    end
  end

  rs_oldest2_select #(
    .N     (RS_SIZE),
    .IDX_W (RS_INDEX_WIDTH)
  ) u_select (
    .ready_i        (ready_vec),
    .ages_i         (age_vec),
    .first_valid_o  (sel0_valid),
    .first_idx_o    (sel0_idx),
    .second_valid_o (sel1_valid),
    .second_idx_o   (sel1_idx)
  );

  assign alloc_ready_o    = any_free & (age_cnt_q != AGE_LAST) & ~flush_i;
  assign alloc_fire       = alloc_valid_i & alloc_ready_o;
  // Issue is masked during reset as well as flush, so no transfer can be
  // observed in a cycle whose state is being discarded.
  assign issue0_valid_o   = sel0_valid & ~flush_i & ~rst_i;
  assign issue1_valid_o   = sel1_valid & ~flush_i & ~rst_i;
  assign issue0_fire      = issue0_valid_o & issue0_ready_i;
  assign issue1_fire      = issue1_valid_o & issue1_ready_i;
  assign issue0_payload_o = ent_q[sel0_idx].payload;
  assign issue1_payload_o = ent_q[sel1_idx].payload;
  assign occupancy_o      = occ_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < RS_SIZE; i++) ent_q[i].valid <= 1'b0;
      age_cnt_q <= '0;
      occ_q     <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent_q[i].valid) begin
          if (wake1[i]) ent_q[i].src1_rdy <= 1'b1;
          if (wake2[i]) ent_q[i].src2_rdy <= 1'b1;
          if ((issue0_fire && (sel0_idx == RS_INDEX_WIDTH'(i))) ||
              (issue1_fire && (sel1_idx == RS_INDEX_WIDTH'(i))))
            ent_q[i].valid <= 1'b0;
        end
      end
      // The target slot is invalid in registered state, so the loop above
      // never writes it in the same cycle.
      if (alloc_fire) begin
        ent_q[free_idx].valid    <= 1'b1;
        ent_q[free_idx].src1_rdy <= alloc_src1_rdy_i | alloc_wake1;
        ent_q[free_idx].src2_rdy <= alloc_src2_rdy_i | alloc_wake2;
        ent_q[free_idx].src1_tag <= alloc_src1_tag_i;
        ent_q[free_idx].src2_tag <= alloc_src2_tag_i;
        ent_q[free_idx].age      <= AGE_W_MAX'(age_cnt_q);
        ent_q[free_idx].payload  <= alloc_payload_i;
      end
      // The age counter never wraps. It only restarts once the station has
      // drained, which keeps ages monotonic among the live entries.
      if (alloc_fire)
        age_cnt_q <= age_cnt_q + AGE_WIDTH'(1);
      else if (occ_q == '0)
        age_cnt_q <= '0;
      occ_q <= occ_q + OCC_W'(alloc_fire) - OCC_W'(issue0_fire) - OCC_W'(issue1_fire);
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Testbench for rs_issue_scheduler: table-driven vectors on the default
// configuration, an issued-payload scoreboard, and a hand-written age-wrap
// sequence on a 3-bit age instance.
module tb_rs_issue_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        flush, alloc_valid, alloc_ready;
  logic [5:0]  src1_tag, src2_tag;
  logic        src1_rdy, src2_rdy;
  logic [31:0] alloc_payload;
  logic [1:0]  wake_valid;
  logic [11:0] wake_tag;
  logic        i0_valid, i0_ready, i1_valid, i1_ready;
  logic [31:0] i0_payload, i1_payload;
  logic [2:0]  occupancy;

  rs_issue_scheduler dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_src1_tag_i(src1_tag), .alloc_src2_tag_i(src2_tag),
    .alloc_src1_rdy_i(src1_rdy), .alloc_src2_rdy_i(src2_rdy),
    .alloc_payload_i(alloc_payload),
    .wakeup_valid_i(wake_valid), .wakeup_tag_i(wake_tag),
    .issue0_valid_o(i0_valid), .issue0_ready_i(i0_ready), .issue0_payload_o(i0_payload),
    .issue1_valid_o(i1_valid), .issue1_ready_i(i1_ready), .issue1_payload_o(i1_payload),
    .occupancy_o(occupancy)
  );

  // ---------------- narrow-age DUT signals ----------------
  logic        w_alloc_valid, w_alloc_ready;
  logic [31:0] w_payload;
  logic        w_i0_valid, w_i0_ready, w_i1_valid, w_i1_ready;
  logic [31:0] w_i0_payload, w_i1_payload;
  logic [2:0]  w_occupancy;

  rs_issue_scheduler #(.AGE_WIDTH(3)) dut_w (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .alloc_valid_i(w_alloc_valid), .alloc_ready_o(w_alloc_ready),
    .alloc_src1_tag_i(6'd0), .alloc_src2_tag_i(6'd0),
    .alloc_src1_rdy_i(1'b1), .alloc_src2_rdy_i(1'b1),
    .alloc_payload_i(w_payload),
    .wakeup_valid_i(2'b00), .wakeup_tag_i(12'd0),
    .issue0_valid_o(w_i0_valid), .issue0_ready_i(w_i0_ready), .issue0_payload_o(w_i0_payload),
    .issue1_valid_o(w_i1_valid), .issue1_ready_i(w_i1_ready), .issue1_payload_o(w_i1_payload),
    .occupancy_o(w_occupancy)
  );

  // ---------------- counters and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected issue of %h with empty queue", name, act);
    end else begin
      chk(name, act, exp_q.pop_front());
    end
  endtask

  // Every accepted issue on the main DUT must match the next expected payload.
  always @(negedge clk) begin
    if (i0_valid && i0_ready) sb_pop("sb_port0", i0_payload);
    if (i1_valid && i1_ready) sb_pop("sb_port1", i1_payload);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pl(input logic [15:0] n);
    return {16'hC0DE, n};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rst, flush, av;
    logic [5:0]  t1;
    logic        r1;
    logic [5:0]  t2;
    logic        r2;
    logic [31:0] pay;
    logic [1:0]  wv;
    logic [11:0] wt;
    logic        i0r, i1r;
    logic        e_ar;
    logic [2:0]  e_occ;
    logic        e_v0;
    logic [31:0] e_p0;
    logic        e_v1;
    logic [31:0] e_p1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic f, input logic av,
                     input logic [5:0] t1, input logic r1, input logic [5:0] t2, input logic r2,
                     input logic [31:0] pay, input logic [1:0] wv, input logic [11:0] wt,
                     input logic i0r, input logic i1r, input logic e_ar, input logic [2:0] e_occ,
                     input logic e_v0, input logic [31:0] e_p0, input logic e_v1, input logic [31:0] e_p1);
    vec_t v;
    v.name = name; v.rst = r; v.flush = f; v.av = av;
    v.t1 = t1; v.r1 = r1; v.t2 = t2; v.r2 = r2; v.pay = pay;
    v.wv = wv; v.wt = wt; v.i0r = i0r; v.i1r = i1r;
    v.e_ar = e_ar; v.e_occ = e_occ; v.e_v0 = e_v0; v.e_p0 = e_p0; v.e_v1 = e_v1; v.e_p1 = e_p1;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; flush = v.flush; alloc_valid = v.av;
    src1_tag = v.t1; src1_rdy = v.r1; src2_tag = v.t2; src2_rdy = v.r2;
    alloc_payload = v.pay; wake_valid = v.wv; wake_tag = v.wt;
    i0_ready = v.i0r; i1_ready = v.i1r;
  endtask

  task automatic idle_main();
    rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0;
    src1_tag = '0; src2_tag = '0; src1_rdy = 1'b0; src2_rdy = 1'b0;
    alloc_payload = '0; wake_valid = '0; wake_tag = '0;
    i0_ready = 1'b0; i1_ready = 1'b0;
  endtask

  initial begin
    // Fill: four ready entries, then port 0/1 show ages 0 and 1.
    add("fill0",      0,0,1, 0,1,0,1, pl(16'h0), 2'b00,12'h000, 0,0, 1,3'd0, 0,0,       0,0);
    add("fill1",      0,0,1, 0,1,0,1, pl(16'h1), 2'b00,12'h000, 0,0, 1,3'd1, 1,pl(16'h0),0,0);
    add("fill2",      0,0,1, 0,1,0,1, pl(16'h2), 2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'h0),1,pl(16'h1));
    add("fill3",      0,0,1, 0,1,0,1, pl(16'h3), 2'b00,12'h000, 0,0, 1,3'd3, 1,pl(16'h0),1,pl(16'h1));
    add("full",       0,0,0, 0,1,0,1, 0,         2'b00,12'h000, 0,0, 0,3'd4, 1,pl(16'h0),1,pl(16'h1));
    add("full_issue", 0,0,1, 0,1,0,1, pl(16'h9), 2'b00,12'h000, 1,1, 0,3'd4, 1,pl(16'h0),1,pl(16'h1));
    add("next_pair",  0,0,0, 0,0,0,0, 0,         2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'h2),1,pl(16'h3));
    add("drain23",    0,0,0, 0,0,0,0, 0,         2'b00,12'h000, 1,1, 1,3'd2, 1,pl(16'h2),1,pl(16'h3));
    add("empty1",     0,0,0, 0,0,0,0, 0,         2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    // Wakeup: A waits on tag 5, B ready; tag 5 broadcast on bus 1.
    add("alloc_a",    0,0,1, 6'd5,0,6'd0,1, pl(16'hA), 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    add("alloc_b",    0,0,1, 6'd0,1,6'd0,1, pl(16'hB), 2'b00,12'h000, 0,0, 1,3'd1, 0,0,0,0);
    add("b_only",     0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'hB),0,0);
    add("wake5",      0,0,0, 0,0,0,0, 0, 2'b11,{6'd5,6'd3}, 0,0, 1,3'd2, 1,pl(16'hB),0,0);
    add("a_woken",    0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'hA),1,pl(16'hB));
    add("drain_ab",   0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 1,1, 1,3'd2, 1,pl(16'hA),1,pl(16'hB));
    add("empty2",     0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    // Same-cycle wakeup during allocation.
    add("alloc_byp",  0,0,1, 6'd7,0,6'd9,1, pl(16'hC), 2'b01,{6'd0,6'd7}, 0,0, 1,3'd0, 0,0,0,0);
    add("byp_issue",  0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 1,1, 1,3'd1, 1,pl(16'hC),0,0);
    add("empty3",     0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    // Port 1 fires while port 0 stalls.
    add("alloc_d",    0,0,1, 0,1,0,1, pl(16'hD), 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    add("alloc_e",    0,0,1, 0,1,0,1, pl(16'hE), 2'b00,12'h000, 0,0, 1,3'd1, 1,pl(16'hD),0,0);
    add("alloc_f",    0,0,1, 0,1,0,1, pl(16'hF), 2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'hD),1,pl(16'hE));
    add("port1_only", 0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,1, 1,3'd3, 1,pl(16'hD),1,pl(16'hE));
    add("hold_d",     0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'hD),1,pl(16'hF));
    add("drain_df",   0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 1,1, 1,3'd2, 1,pl(16'hD),1,pl(16'hF));
    add("empty4",     0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    // Flush with three entries and a pending allocation.
    add("alloc_g",    0,0,1, 0,1,0,1, pl(16'h10), 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    add("alloc_h",    0,0,1, 0,1,0,1, pl(16'h11), 2'b00,12'h000, 0,0, 1,3'd1, 1,pl(16'h10),0,0);
    add("alloc_i",    0,0,1, 0,1,0,1, pl(16'h12), 2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'h10),1,pl(16'h11));
    add("flush",      0,1,1, 0,1,0,1, pl(16'h13), 2'b00,12'h000, 1,1, 0,3'd3, 0,0,0,0);
    add("post_flush", 0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 1,1, 1,3'd0, 0,0,0,0);
    add("alloc_k",    0,0,1, 0,1,0,1, pl(16'h14), 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    add("k_issue",    0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 1,1, 1,3'd1, 1,pl(16'h14),0,0);
    add("empty5",     0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    // Reset with three entries and a pending allocation.
    add("alloc_l",    0,0,1, 0,1,0,1, pl(16'h20), 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    add("alloc_m",    0,0,1, 0,1,0,1, pl(16'h21), 2'b00,12'h000, 0,0, 1,3'd1, 1,pl(16'h20),0,0);
    add("alloc_n",    0,0,1, 0,1,0,1, pl(16'h22), 2'b00,12'h000, 0,0, 1,3'd2, 1,pl(16'h20),1,pl(16'h21));
    add("reset",      1,0,1, 0,1,0,1, pl(16'h23), 2'b00,12'h000, 1,1, 1,3'd3, 0,0,0,0);
    add("post_reset", 0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 1,1, 1,3'd0, 0,0,0,0);
    add("alloc_q",    0,0,1, 0,1,0,1, pl(16'h24), 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);
    add("q_issue",    0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 1,1, 1,3'd1, 1,pl(16'h24),0,0);
    add("empty6",     0,0,0, 0,0,0,0, 0, 2'b00,12'h000, 0,0, 1,3'd0, 0,0,0,0);

    // Reset phase.
    idle_main();
    rst = 1'b1;
    w_alloc_valid = 1'b0; w_payload = '0; w_i0_ready = 1'b0; w_i1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven section.
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      if (vecs[k].i0r && vecs[k].e_v0) exp_q.push_back(vecs[k].e_p0);
      if (vecs[k].i1r && vecs[k].e_v1) exp_q.push_back(vecs[k].e_p1);
      @(negedge clk);
      chk({vecs[k].name, ".alloc_ready"}, 32'(alloc_ready), 32'(vecs[k].e_ar));
      chk({vecs[k].name, ".occupancy"},   32'(occupancy),   32'(vecs[k].e_occ));
      chk({vecs[k].name, ".issue0_valid"}, 32'(i0_valid),   32'(vecs[k].e_v0));
      chk({vecs[k].name, ".issue1_valid"}, 32'(i1_valid),   32'(vecs[k].e_v1));
      if (vecs[k].e_v0) chk({vecs[k].name, ".issue0_payload"}, i0_payload, vecs[k].e_p0);
      if (vecs[k].e_v1) chk({vecs[k].name, ".issue1_payload"}, i1_payload, vecs[k].e_p1);
      @(posedge clk);
      #1;
    end
    idle_main();

    // Age-wrap sequence on the 3-bit age instance: one allocation per cycle,
    // each issued the following cycle.
    w_alloc_valid = 1'b1; w_i0_ready = 1'b1; w_i1_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      w_payload = pl(16'h100 + 16'(k));
      @(negedge clk);
      chk($sformatf("wrap%0d.alloc_ready", k), 32'(w_alloc_ready), 32'd1);
      chk($sformatf("wrap%0d.occupancy", k), 32'(w_occupancy), (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("wrap%0d.issue1_valid", k), 32'(w_i1_valid), 32'd0);
      if (k > 0) begin
        chk($sformatf("wrap%0d.issue0_valid", k), 32'(w_i0_valid), 32'd1);
        chk($sformatf("wrap%0d.issue0_payload", k), w_i0_payload, pl(16'h100 + 16'(k - 1)));
      end
      @(posedge clk);
      #1;
    end
    // age_cnt is now all-ones: allocation stalls.
    w_payload = pl(16'h107);
    @(negedge clk);
    chk("wrap_stall.alloc_ready", 32'(w_alloc_ready), 32'd0);
    chk("wrap_stall.occupancy", 32'(w_occupancy), 32'd1);
    chk("wrap_stall.issue0_valid", 32'(w_i0_valid), 32'd1);
    chk("wrap_stall.issue0_payload", w_i0_payload, pl(16'h106));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wrap_empty.occupancy", 32'(w_occupancy), 32'd0);
    chk("wrap_empty.alloc_ready", 32'(w_alloc_ready), 32'd0);
    chk("wrap_empty.issue0_valid", 32'(w_i0_valid), 32'd0);
    @(posedge clk);
    #1;
    w_payload = pl(16'h109);
    @(negedge clk);
    chk("wrap_restart.alloc_ready", 32'(w_alloc_ready), 32'd1);
    @(posedge clk);
    #1;
    w_alloc_valid = 1'b0;
    @(negedge clk);
    chk("wrap_after.occupancy", 32'(w_occupancy), 32'd1);
    chk("wrap_after.issue0_valid", 32'(w_i0_valid), 32'd1);
    chk("wrap_after.issue0_payload", w_i0_payload, pl(16'h109));
    @(posedge clk);
    #1;
    w_i0_ready = 1'b0; w_i1_ready = 1'b0;
    @(negedge clk);
    chk("wrap_drained.occupancy", 32'(w_occupancy), 32'd0);

    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
